// File: rtl/fp_trace_writer.sv
// fp_trace_writer: pairs issued FP operations with their in-order results,
// builds one 288-bit trace record per completed operation and streams each
// record out as nine 32-bit words, MSB word first.
module fp_trace_writer #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_data1,
  input  logic [63:0] req_data2,
  input  logic [63:0] req_data3,
  input  logic [1:0]  req_fmt,
  input  logic [2:0]  req_rm,
  input  logic [1:0]  req_op,
  input  logic [9:0]  req_opcode,
  input  logic        rsp_ready,
  input  logic [63:0] rsp_result,
  input  logic [4:0]  rsp_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic [15:0] rec_count,
  output logic        err_overflow,
  output logic        err_orphan
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [63:0] data1;
    logic [63:0] data2;
    logic [63:0] data3;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [1:0]  op;
    logic [9:0]  opcode;
  } pend_t;

  typedef enum logic {IDLE, SEND} state_t;

  // Word idx of a record, counting from the MSB end.
  function automatic logic [31:0] word_sel(input logic [287:0] rec, input logic [3:0] idx);
    word_sel = rec[(8 - int'(idx)) * 32 +: 32];
  endfunction

  // ---------------- pending-request FIFO ----------------
  pend_t          pend_mem [DEPTH];
  logic [AW-1:0]  pend_rd_q, pend_wr_q;
  logic [CW-1:0]  pend_cnt_q;
  logic           pend_empty, pend_full, pend_pop, pend_push;
  pend_t          pend_head, req_entry;

  assign pend_empty = (pend_cnt_q == '0);
  assign pend_full  = (pend_cnt_q == CW'(DEPTH));
  // A response only ever matches an already-queued request.
  assign pend_pop   = rsp_ready && !pend_empty;
  // A full FIFO still takes a push when its head leaves in the same cycle.
  assign pend_push  = req_valid && (!pend_full || pend_pop);
  assign pend_head  = pend_mem[pend_rd_q];
  assign req_entry  = '{req_data1, req_data2, req_data3, req_fmt, req_rm, req_op, req_opcode};

  // Pending FIFO storage.
  // NOTE: storage arrays carry no reset; validity lives in the pointers and count.
  always_ff @(posedge clock) begin
    if (pend_push) pend_mem[pend_wr_q] <= req_entry;
  end

  // Pending FIFO pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of its neighbours.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_rd_q  <= '0;
      pend_wr_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (pend_push) pend_wr_q <= pend_wr_q + AW'(1);
      if (pend_pop)  pend_rd_q <= pend_rd_q + AW'(1);
      case ({pend_push, pend_pop})
        2'b10:   pend_cnt_q <= pend_cnt_q + CW'(1);
        2'b01:   pend_cnt_q <= pend_cnt_q - CW'(1);
        default: pend_cnt_q <= pend_cnt_q;
      endcase
    end
  end

  // ---------------- record FIFO ----------------
  logic [287:0]   rec_mem [DEPTH];
  logic [AW-1:0]  rec_rd_q, rec_wr_q, rec_rd_nxt;
  logic [CW-1:0]  rec_cnt_q;
  logic           rec_full, rec_push, rec_pop;
  logic [287:0]   rec_new, rec_head, rec_next_head;

  state_t         state_q;
  logic [3:0]     widx_q;

  assign rec_new = {pend_head.data1, pend_head.data2, pend_head.data3, rsp_result,
                    3'b000, rsp_flags, 2'b00, pend_head.fmt, 1'b0, pend_head.rm,
                    2'b00, pend_head.op, 2'b00, pend_head.opcode};
  // A full record FIFO refuses the merged record even if it drains this cycle.
  assign rec_full   = (rec_cnt_q == CW'(DEPTH));
  assign rec_push   = pend_pop && !rec_full;
  assign rec_pop    = (state_q == SEND) && out_ready && (widx_q == 4'd8);
  assign rec_rd_nxt = rec_rd_q + AW'(1);
  assign rec_head   = rec_mem[rec_rd_q];
  // Record that becomes the head after a pop: the one behind the current head,
  // or the record being written right now when the FIFO holds only one.
  assign rec_next_head = (rec_cnt_q > CW'(1)) ? rec_mem[rec_rd_nxt] : rec_new;

  // Record FIFO storage.
  always_ff @(posedge clock) begin
    if (rec_push) rec_mem[rec_wr_q] <= rec_new;
  end

  // Record FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rec_rd_q  <= '0;
      rec_wr_q  <= '0;
      rec_cnt_q <= '0;
    end else begin
      if (rec_push) rec_wr_q <= rec_wr_q + AW'(1);
      if (rec_pop)  rec_rd_q <= rec_rd_nxt;
      case ({rec_push, rec_pop})
        2'b10:   rec_cnt_q <= rec_cnt_q + CW'(1);
        2'b01:   rec_cnt_q <= rec_cnt_q - CW'(1);
        default: rec_cnt_q <= rec_cnt_q;
      endcase
    end
  end

  // Serializer FSM with registered word, valid and last outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      widx_q      <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      rec_count   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rec_cnt_q != '0) begin
            state_q   <= SEND;
            widx_q    <= '0;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            out_data  <= word_sel(rec_head, 4'd0);
          end
        end
        SEND: begin
          if (out_ready) begin
            if (widx_q == 4'd8) begin
              rec_count <= rec_count + 16'd1;
              out_last  <= 1'b0;
              widx_q    <= '0;
              if (rec_cnt_q > CW'(1) || rec_push) begin
                out_data <= word_sel(rec_next_head, 4'd0);
              end else begin
                state_q   <= IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              widx_q   <= widx_q + 4'd1;
              out_data <= word_sel(rec_head, widx_q + 4'd1);
              out_last <= (widx_q == 4'd7);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky error flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      err_overflow <= 1'b0;
      err_orphan   <= 1'b0;
    end else begin
      if ((req_valid && !pend_push) || (pend_pop && rec_full)) err_overflow <= 1'b1;
      if (rsp_ready && pend_empty) err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_trace_writer.sv
// Testbench for fp_trace_writer: directed scenarios followed by random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_fp_trace_writer;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_data1, req_data2, req_data3;
  logic [1:0]  req_fmt;
  logic [2:0]  req_rm;
  logic [1:0]  req_op;
  logic [9:0]  req_opcode;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic [15:0] rec_count;
  logic        err_overflow;
  logic        err_orphan;

  fp_trace_writer #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
    .req_fmt(req_fmt), .req_rm(req_rm), .req_op(req_op), .req_opcode(req_opcode),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .rec_count(rec_count), .err_overflow(err_overflow), .err_orphan(err_orphan)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] d1, d2, d3;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [1:0]  op;
    logic [9:0]  opcode;
  } req_t;

  // Reference model state
  req_t         m_pend[$];
  logic [287:0] m_rec[$];
  bit           m_send;
  int           m_widx;
  int           m_count;
  bit           m_ovf, m_orph;

  // Words accepted by the sink
  logic [31:0] cap[$];
  logic        cap_last[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [287:0] make_rec(input req_t r, input logic [63:0] res, input logic [4:0] fl);
    logic [287:0] x;
    x = '0;
    x[287:224] = r.d1;
    x[223:160] = r.d2;
    x[159:96]  = r.d3;
    x[95:32]   = res;
    x[28:24]   = fl;
    x[21:20]   = r.fmt;
    x[18:16]   = r.rm;
    x[13:12]   = r.op;
    x[9:0]     = r.opcode;
    return x;
  endfunction

  function automatic logic [31:0] word_of(input logic [287:0] rec, input int idx);
    logic [287:0] s;
    s = rec >> (32 * (8 - idx));
    return s[31:0];
  endfunction

  function automatic req_t cur_req();
    req_t r;
    r.d1 = req_data1; r.d2 = req_data2; r.d3 = req_data3;
    r.fmt = req_fmt; r.rm = req_rm; r.op = req_op; r.opcode = req_opcode;
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int pend_n, rec_n;
    bit pop_p, rec_ok, done;
    logic [287:0] nrec;
    if (!reset) begin
      m_pend.delete(); m_rec.delete();
      m_send = 0; m_widx = 0; m_count = 0; m_ovf = 0; m_orph = 0;
      return;
    end
    pend_n = m_pend.size();
    rec_n  = m_rec.size();
    pop_p  = rsp_ready && pend_n > 0;
    rec_ok = 0;
    done   = 0;
    nrec   = '0;
    if (rsp_ready && pend_n == 0) m_orph = 1;
    if (pop_p) begin
      nrec = make_rec(m_pend[0], rsp_result, rsp_flags);
      if (rec_n == DEPTH) m_ovf = 1; else rec_ok = 1;
      void'(m_pend.pop_front());
    end
    if (req_valid) begin
      if (pend_n < DEPTH || pop_p) m_pend.push_back(cur_req());
      else m_ovf = 1;
    end
    if (!m_send) begin
      if (rec_n > 0) begin m_send = 1; m_widx = 0; end
    end else if (out_ready) begin
      if (m_widx < 8) m_widx++;
      else begin
        void'(m_rec.pop_front());
        m_count = (m_count + 1) % 65536;
        done = 1;
      end
    end
    if (rec_ok) m_rec.push_back(nrec);
    if (done) begin
      m_widx = 0;
      if (m_rec.size() == 0) m_send = 0;
    end
  endtask

  task automatic compare_all();
    check("out_valid", 64'(out_valid), 64'(m_send));
    check("out_last", 64'(out_last), 64'(m_send && m_widx == 8));
    if (m_send) check("out_data", 64'(out_data), 64'(word_of(m_rec[0], m_widx)));
    check("rec_count", 64'(rec_count), 64'(m_count));
    check("err_overflow", 64'(err_overflow), 64'(m_ovf));
    check("err_orphan", 64'(err_orphan), 64'(m_orph));
  endtask

  task automatic tick();
    if (out_valid && out_ready && reset) begin
      cap.push_back(out_data);
      cap_last.push_back(out_last);
    end
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic set_idle();
    req_valid = 0; rsp_ready = 0; out_ready = 0;
    req_data1 = '0; req_data2 = '0; req_data3 = '0;
    req_fmt = '0; req_rm = '0; req_op = '0; req_opcode = '0;
    rsp_result = '0; rsp_flags = '0;
  endtask

  task automatic rand_req();
    req_data1 = {$urandom, $urandom}; req_data2 = {$urandom, $urandom};
    req_data3 = {$urandom, $urandom};
    req_fmt = 2'($urandom); req_rm = 3'($urandom); req_op = 2'($urandom);
    req_opcode = 10'(1 << $urandom_range(0, 9));
  endtask

  task automatic do_reset();
    set_idle();
    reset = 0;
    tick();
    tick();
    reset = 1;
    cap.delete(); cap_last.delete();
  endtask

  initial begin
    req_t         r;
    logic [287:0] exp_rec;
    logic [287:0] recs[$];
    int           k;

    set_idle();
    reset = 0;

    // Reset state
    do_reset();
    check("reset_out_data", 64'(out_data), 64'h0);

    // Single known record, latency and word contents
    out_ready = 1;
    req_valid = 1; req_data1 = 64'h3FF0000000000000; req_data2 = 64'h4000000000000000;
    req_data3 = '0; req_fmt = 2'd1; req_rm = 3'd0; req_op = 2'd0; req_opcode = 10'h002;
    tick();
    req_valid = 0;
    rsp_ready = 1; rsp_result = 64'h4008000000000000; rsp_flags = 5'd0;
    tick();
    rsp_ready = 0;
    tick();
    check("latency_2cyc", 64'(out_valid), 64'h1);
    for (int i = 0; i < 14; i++) tick();
    check("known_nwords", 64'(cap.size()), 64'd9);
    if (cap.size() >= 9) begin
      check("known_w0", 64'(cap[0]), 64'h3FF00000);
      check("known_w6", 64'(cap[6]), 64'h40080000);
      check("known_w7", 64'(cap[7]), 64'h00000000);
      check("known_w8", 64'(cap[8]), 64'h00100002);
      check("known_last8", 64'(cap_last[8]), 64'h1);
      check("known_last7", 64'(cap_last[7]), 64'h0);
    end
    check("known_rec_count", 64'(rec_count), 64'd1);

    // Stalls: out_ready toggling every cycle
    do_reset();
    rand_req(); r = cur_req(); req_valid = 1;
    tick();
    req_valid = 0; rsp_ready = 1; rsp_result = {$urandom, $urandom}; rsp_flags = 5'($urandom);
    exp_rec = make_rec(r, rsp_result, rsp_flags);
    tick();
    rsp_ready = 0;
    for (int i = 0; i < 40; i++) begin
      out_ready = i[0];
      tick();
    end
    check("stall_nwords", 64'(cap.size()), 64'd9);
    for (int i = 0; i < 9 && i < cap.size(); i++) begin
      check($sformatf("stall_w%0d", i), 64'(cap[i]), 64'(word_of(exp_rec, i)));
      check($sformatf("stall_last%0d", i), 64'(cap_last[i]), 64'(i == 8));
    end

    // Pending overflow, then DEPTH records in order
    do_reset();
    recs.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      rand_req(); req_valid = 1;
      if (i < DEPTH) begin r = cur_req(); recs.push_back(make_rec(r, 64'h0, 5'h0)); end
      tick();
    end
    req_valid = 0;
    check("pend_overflow", 64'(err_overflow), 64'h1);
    out_ready = 1;
    for (int i = 0; i < DEPTH; i++) begin
      rsp_ready = 1; rsp_result = {$urandom, $urandom}; rsp_flags = 5'($urandom);
      recs[i][95:32] = rsp_result; recs[i][28:24] = rsp_flags;
      tick();
    end
    rsp_ready = 0;
    for (int i = 0; i < 9 * DEPTH + 10; i++) tick();
    check("ovf_nwords", 64'(cap.size()), 64'(9 * DEPTH));
    check("ovf_rec_count", 64'(rec_count), 64'(DEPTH));
    for (int i = 0; i < 9 * DEPTH && i < cap.size(); i++)
      check($sformatf("ovf_rec%0d_w%0d", i / 9, i % 9), 64'(cap[i]), 64'(word_of(recs[i / 9], i % 9)));

    // Orphan response
    do_reset();
    out_ready = 1; rsp_ready = 1; rsp_result = {$urandom, $urandom};
    tick();
    rsp_ready = 0;
    check("orphan_flag", 64'(err_orphan), 64'h1);
    for (int i = 0; i < 5; i++) tick();
    check("orphan_rec_count", 64'(rec_count), 64'h0);
    check("orphan_nwords", 64'(cap.size()), 64'h0);

    // Full pending FIFO with push and pop in the same cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin rand_req(); req_valid = 1; tick(); end
    rand_req(); req_valid = 1; rsp_ready = 1; out_ready = 1;
    tick();
    check("full_pushpop_no_ovf", 64'(err_overflow), 64'h0);
    rsp_ready = 0; rand_req(); req_valid = 1;
    tick();
    req_valid = 0;
    check("full_still_full", 64'(err_overflow), 64'h1);
    for (int i = 0; i < 12; i++) tick();

    // Reset in the middle of a record
    do_reset();
    rand_req(); r = cur_req(); req_valid = 1; out_ready = 1;
    tick();
    req_valid = 0; rsp_ready = 1; rsp_result = {$urandom, $urandom}; rsp_flags = 5'($urandom);
    exp_rec = make_rec(r, rsp_result, rsp_flags);
    tick();
    rsp_ready = 0;
    k = 0;
    while (k < 20 && !(m_send && m_widx == 4)) begin tick(); k++; end
    check("mid_widx4_word", 64'(out_data), 64'(word_of(exp_rec, 4)));
    reset = 0;
    tick();
    reset = 1;
    check("mid_reset_valid", 64'(out_valid), 64'h0);
    check("mid_reset_count", 64'(rec_count), 64'h0);
    rand_req(); r = cur_req(); req_valid = 1;
    tick();
    req_valid = 0; rsp_ready = 1; rsp_result = {$urandom, $urandom}; rsp_flags = 5'($urandom);
    exp_rec = make_rec(r, rsp_result, rsp_flags);
    tick();
    rsp_ready = 0;
    cap.delete(); cap_last.delete();
    for (int i = 0; i < 14; i++) tick();
    check("post_reset_nwords", 64'(cap.size()), 64'd9);
    if (cap.size() >= 1) check("post_reset_w0", 64'(cap[0]), 64'(word_of(exp_rec, 0)));

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 499) != 0);
      req_valid = ($urandom_range(0, 99) < 50);
      rand_req();
      rsp_ready = ($urandom_range(0, 99) < 40);
      rsp_result = {$urandom, $urandom};
      rsp_flags = 5'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    reset = 1;
    set_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
